seq_mult: RTL and testbench
===========================

SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 32, giving the operand width in bits (>=2).
REQ-002 The block SHALL have parameter OUT_WIDTH, default 32, giving the result width in bits (>=1).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- go  in  1  start request; sampled on the rising edge of clk
- left  in  IN_WIDTH  unsigned multiplicand; sampled with go
- right  in  IN_WIDTH  unsigned multiplier; sampled with go
- out  out  OUT_WIDTH  registered product
- done  out  1  one-cycle completion pulse
- busy  out  1  high while in RUN

Function
REQ-004 The block SHALL implement a 3-state FSM with states IDLE, RUN and DONE.
REQ-005 In IDLE with go=1 at a rising edge, the block SHALL:
- latch left and right into internal operand registers;
- clear an internal 2*IN_WIDTH-bit accumulator;
- clear the iteration counter;
- enter RUN.
REQ-006 In IDLE with go=0, the block SHALL remain in IDLE.
REQ-007 In RUN, each cycle the block SHALL perform one shift-add step:
- if multiplier bit 0 is 1, add the shifted multiplicand to the accumulator;
- shift the multiplicand left by 1;
- shift the multiplier right by 1;
- increment the counter.
REQ-008 RUN SHALL last exactly IN_WIDTH cycles regardless of operand values; there is no early exit when an operand is zero.
REQ-009 On the edge that completes the IN_WIDTH-th step, the block SHALL:
- load out with accumulator bits [OUT_WIDTH-1:0], zero-extended if OUT_WIDTH > 2*IN_WIDTH;
- enter DONE.
REQ-010 Arithmetic SHALL be unsigned modulo 2^OUT_WIDTH; the accumulator SHALL never overflow internally (2*IN_WIDTH bits).
REQ-011 done SHALL be 1 exactly in the DONE cycle and 0 otherwise.
REQ-012 busy SHALL be 1 exactly in RUN cycles.
REQ-013 Latency: go high in cycle 0 SHALL yield done=1 and a valid out in cycle IN_WIDTH+1.
REQ-014 From DONE, the block SHALL enter RUN if go=1 (back-to-back accept, operands latched as in REQ-005), else IDLE.
REQ-015 go during RUN SHALL be ignored; operands and the counter SHALL be unaffected.
REQ-016 out SHALL hold its value from one completion until the next completion and SHALL NOT change on accept or during RUN.
REQ-017 Changes on left/right after the accept edge SHALL NOT affect the result in progress.

Reset
REQ-018 On reset assertion, the block SHALL asynchronously force:
- state=IDLE;
- out=0, done=0, busy=0;
- accumulator, operand registers and counter to 0.
REQ-019 Reset asserted mid-RUN or in DONE SHALL abandon the operation; no done pulse SHALL follow for it.
REQ-020 The first go after reset deasserts SHALL be accepted on the first rising edge at which reset is low.

Verification
REQ-021 With IN_WIDTH=8 and OUT_WIDTH=16: go with left=3, right=5 in cycle 0 -> busy in cycles 1..8; done=1 and out=15 in cycle 9; done=0 in cycle 10; out stays 15.
REQ-022 With IN_WIDTH=8 and OUT_WIDTH=16: left=255, right=255 -> out=65025 (0xFE01) in cycle 9. With OUT_WIDTH=8 and the same operands -> out=0x01.
REQ-023 Operand-change and mid-RUN go: go with 7x9, then in cycle 3 drive go=1 with left=2, right=2 -> out=63 in cycle 9, with no second accept.
REQ-024 Back-to-back and zero operand: go with 7x9, then go with 0x200 held high in the done cycle (cycle 9) -> done in cycle 18 with out=0; out=63 held during cycles 10..17.
REQ-025 Reset mid-operation: reset asserted in cycle 4 of a run -> out=0, busy=0 immediately; no done pulse afterward. A new go of 4x4 -> out=16 after IN_WIDTH+1 cycles.

Source files
------------

// File: rtl/seq_mult.sv
// Sequential shift-add unsigned multiplier: IN_WIDTH-cycle RUN phase, one-cycle
// DONE pulse, registered product truncated or zero-extended to OUT_WIDTH bits.
module seq_mult #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic [IN_WIDTH-1:0]  left,
  input  logic [IN_WIDTH-1:0]  right,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 done,
  output logic                 busy
);

  localparam int ACC_W = 2 * IN_WIDTH;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [ACC_W-1:0]     mcand_q, mcand_d;
  logic [IN_WIDTH-1:0]  mplier_q, mplier_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] out_q, out_d;

  logic [ACC_W-1:0]     acc_step;
  logic [OUT_WIDTH-1:0] prod_ext;

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // The final step's partial sum feeds out directly so the product is valid in DONE.
  generate
    if (OUT_WIDTH <= ACC_W) begin : g_trunc
      assign prod_ext = acc_step[OUT_WIDTH-1:0];
    end else begin : g_zext
      assign prod_ext = {{(OUT_WIDTH - ACC_W){1'b0}}, acc_step};
    end
  endgenerate

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    out_d    = out_q;

    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          mcand_d  = {{IN_WIDTH{1'b0}}, left};
          mplier_d = right;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          out_d   = prod_ext;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  assign out  = out_q;
  assign done = (state_q == DONE);
  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_seq_mult.sv
// Directed testbench for seq_mult: IN_WIDTH=8 with OUT_WIDTH=16 and OUT_WIDTH=8
// instances sharing the same stimulus.
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [7:0]  left, right;
  logic [15:0] out16;
  logic [7:0]  out8;
  logic        done16, busy16, done8, busy8;

  int tests_run    = 0;
  int tests_failed = 0;

  seq_mult #(.IN_WIDTH(8), .OUT_WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .go(go), .left(left), .right(right),
    .out(out16), .done(done16), .busy(busy16)
  );

  seq_mult #(.IN_WIDTH(8), .OUT_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .go(go), .left(left), .right(right),
    .out(out8), .done(done8), .busy(busy8)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] a, input logic [7:0] b);
    go    = 1'b1;
    left  = a;
    right = b;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    go    = 1'b0;
    left  = '0;
    right = '0;
    step();
    step();
    tests_run++;
    if (out16 !== 16'd0 || done16 !== 1'b0 || busy16 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state16: out=%0d done=%b busy=%b, want 0 0 0", out16, done16, busy16);
    end
    tests_run++;
    if (out8 !== 8'd0 || done8 !== 1'b0 || busy8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state8: out=%0d done=%b busy=%b, want 0 0 0", out8, done8, busy8);
    end
    reset = 1'b0;
  endtask

  // 3x5 launched in the same cycle reset drops: first edge with reset low accepts it.
  task automatic test_basic();
    start(8'd3, 8'd5);
    for (int c = 1; c <= 8; c++) begin
      step();
      go = 1'b0;
      tests_run++;
      if (busy16 !== 1'b1 || done16 !== 1'b0) begin
        tests_failed++;
        $display("FAIL basic_busy_c%0d: busy=%b done=%b, want 1 0", c, busy16, done16);
      end
    end
    step();
    tests_run++;
    if (done16 !== 1'b1 || busy16 !== 1'b0 || out16 !== 16'd15) begin
      tests_failed++;
      $display("FAIL basic_done_c9: done=%b busy=%b out=%0d, want 1 0 15", done16, busy16, out16);
    end
    step();
    tests_run++;
    if (done16 !== 1'b0 || busy16 !== 1'b0 || out16 !== 16'd15) begin
      tests_failed++;
      $display("FAIL basic_hold_c10: done=%b busy=%b out=%0d, want 0 0 15", done16, busy16, out16);
    end
  endtask

  task automatic test_max_operands();
    start(8'd255, 8'd255);
    step();
    go = 1'b0;
    for (int c = 2; c <= 9; c++) step();
    tests_run++;
    if (done16 !== 1'b1 || out16 !== 16'hFE01) begin
      tests_failed++;
      $display("FAIL max_out16: done=%b out=%h, want 1 fe01", done16, out16);
    end
    tests_run++;
    if (done8 !== 1'b1 || out8 !== 8'h01) begin
      tests_failed++;
      $display("FAIL max_out8: done=%b out=%h, want 1 01", done8, out8);
    end
    step();
  endtask

  // go and operand changes during RUN must not disturb the 7x9 in progress.
  task automatic test_mid_run_go();
    start(8'd7, 8'd9);
    step();
    go    = 1'b0;
    left  = 8'd200;
    right = 8'd100;
    step();
    step();
    start(8'd2, 8'd2);
    step();
    go = 1'b0;
    for (int c = 5; c <= 9; c++) step();
    tests_run++;
    if (done16 !== 1'b1 || out16 !== 16'd63) begin
      tests_failed++;
      $display("FAIL midgo_done_c9: done=%b out=%0d, want 1 63", done16, out16);
    end
    tests_run++;
    if (out8 !== 8'd63) begin
      tests_failed++;
      $display("FAIL midgo_out8: out=%0d, want 63", out8);
    end
    step();
    tests_run++;
    if (busy16 !== 1'b0 || done16 !== 1'b0 || out16 !== 16'd63) begin
      tests_failed++;
      $display("FAIL midgo_no_reaccept_c10: busy=%b done=%b out=%0d, want 0 0 63", busy16, done16, out16);
    end
  endtask

  task automatic test_reset_mid_run();
    int done_seen;
    start(8'd7, 8'd9);
    step();
    go = 1'b0;
    for (int c = 2; c <= 4; c++) step();
    reset = 1'b1;
    #1;
    tests_run++;
    if (out16 !== 16'd0 || busy16 !== 1'b0 || done16 !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_async: out=%0d busy=%b done=%b, want 0 0 0", out16, busy16, done16);
    end
    step();
    reset = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (done16 === 1'b1 || busy16 === 1'b1) done_seen++;
    end
    tests_run++;
    if (done_seen != 0) begin
      tests_failed++;
      $display("FAIL rst_mid_no_done: activity cycles=%0d, want 0", done_seen);
    end
    start(8'd4, 8'd4);
    step();
    go = 1'b0;
    for (int c = 2; c <= 9; c++) step();
    tests_run++;
    if (done16 !== 1'b1 || out16 !== 16'd16) begin
      tests_failed++;
      $display("FAIL rst_mid_rerun: done=%b out=%0d, want 1 16", done16, out16);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int bad_hold;
    start(8'd7, 8'd9);
    step();
    go = 1'b0;
    for (int c = 2; c <= 9; c++) step();
    tests_run++;
    if (done16 !== 1'b1 || out16 !== 16'd63) begin
      tests_failed++;
      $display("FAIL b2b_first_c9: done=%b out=%0d, want 1 63", done16, out16);
    end
    start(8'd0, 8'd200);
    bad_hold = 0;
    for (int c = 10; c <= 17; c++) begin
      step();
      go = 1'b0;
      if (busy16 !== 1'b1 || done16 !== 1'b0 || out16 !== 16'd63) bad_hold++;
    end
    tests_run++;
    if (bad_hold != 0) begin
      tests_failed++;
      $display("FAIL b2b_hold_c10_17: bad cycles=%0d, want 0 (busy=1 done=0 out=63)", bad_hold);
    end
    step();
    tests_run++;
    if (done16 !== 1'b1 || out16 !== 16'd0) begin
      tests_failed++;
      $display("FAIL b2b_second_c18: done=%b out=%0d, want 1 0", done16, out16);
    end
    step();
    tests_run++;
    if (done16 !== 1'b0 || busy16 !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle_c19: done=%b busy=%b, want 0 0", done16, busy16);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_operands();
    test_mid_run_go();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
